prog_loader: RTL

Writable instruction store and its stream loader for the pipelined 9-bit CPU. It replaces a fixed program ROM with a 256 x 9 RAM that is filled from a 9-bit word stream over a valid/ready handshake. The CPU is held in stall until a complete program has been written. The fetch stage then reads the RAM through the same pc → instr_out interface a ROM presents.

---
 rtl/prog_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Writable 256x9 instruction store with a valid/ready stream loader that stalls the CPU until a program is loaded.
// Optional trailing XOR checksum word enabled by defining PROG_LOADER_CKSUM_EN.
module prog_loader (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   input  logic [8:0] in_data,
   output logic       in_ready,
   input  logic [7:0] pc,
   output logic [8:0] instr_out,
   output logic       cpu_hold,
   output logic       load_done,
   output logic       load_err,
   output logic [7:0] words_loaded
);

   localparam int unsigned DW    = 9;
   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 256;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_LOAD,
`ifdef PROG_LOADER_CKSUM_EN
      ST_CHK,
`endif
      ST_DONE,
      ST_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   len_q, len_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [AW-1:0]   words_q, words_d;
   logic            cpu_hold_q, cpu_hold_d;
   logic            load_done_q, load_done_d;
   logic            load_err_q, load_err_d;
   logic            we_c;
   logic            last_c;
`ifdef PROG_LOADER_CKSUM_EN
   logic [DW-1:0]   cksum_q, cksum_d;
`endif

   logic [DW-1:0]   mem [DEPTH];

   // State and bookkeeping registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         wr_addr_q   <= '0;
         words_q     <= '0;
         cpu_hold_q  <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
         cksum_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         wr_addr_q   <= wr_addr_d;
         words_q     <= words_d;
         cpu_hold_q  <= cpu_hold_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
`ifdef PROG_LOADER_CKSUM_EN
         cksum_q     <= cksum_d;
`endif
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wr_addr_d = wr_addr_q;
      words_d   = words_q;
      we_c      = 1'b0;
      in_ready  = 1'b0;
      last_c    = (words_q == (len_q - AW'(1)));
`ifdef PROG_LOADER_CKSUM_EN
      cksum_d   = cksum_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LEN;
               words_d = '0;
`ifdef PROG_LOADER_CKSUM_EN
               cksum_d = '0;
`endif
            end
         end
         ST_LEN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data[8] || (in_data[7:0] == '0)) begin
                  state_d = ST_ERR;
               end else begin
                  len_d     = in_data[7:0];
                  wr_addr_d = AW'(1);
                  state_d   = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               we_c    = 1'b1;
               words_d = words_q + AW'(1);
`ifdef PROG_LOADER_CKSUM_EN
               cksum_d = cksum_q ^ in_data;
`endif
               // Hold the address on the last word so a 255-word program never wraps to 0
               if (last_c) begin
`ifdef PROG_LOADER_CKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  wr_addr_d = wr_addr_q + AW'(1);
               end
            end
         end
`ifdef PROG_LOADER_CKSUM_EN
         ST_CHK: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = (in_data == cksum_q) ? ST_DONE : ST_ERR;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      cpu_hold_d  = (state_d != ST_DONE);
      load_done_d = (state_d == ST_DONE);
      load_err_d  = (state_d == ST_ERR);
   end

   // Instruction RAM: not reset, address 0 never written
   always_ff @(posedge clk) begin
      if (we_c && !reset) begin
         mem[wr_addr_q] <= in_data;
      end
   end

   assign instr_out    = (pc == '0) ? '0 : mem[pc];
   assign cpu_hold     = cpu_hold_q;
   assign load_done    = load_done_q;
   assign load_err     = load_err_q;
   assign words_loaded = words_q;

endmodule
